// File: rtl/dds_phase_gen_if.sv
// DDS phase generator bus: config handshake in, ROM address and aligned flags out.
// master drives run-enable and configuration; slave is the phase generator.
interface dds_phase_gen_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10
);
  logic                   en;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [PHASE_WIDTH-1:0] cfg_freq;
  logic [ADDR_WIDTH-1:0]  cfg_phase;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic                   addr_valid;
  logic                   wrap;
  logic                   data_valid;
  logic                   sample_sync;

  modport master (
    output en, cfg_valid, cfg_freq, cfg_phase,
    input  cfg_ready, rom_addr, addr_valid, wrap, data_valid, sample_sync
  );

  modport slave (
    input  en, cfg_valid, cfg_freq, cfg_phase,
    output cfg_ready, rom_addr, addr_valid, wrap, data_valid, sample_sync
  );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator / ROM address generator; rom_addr registered (1 clk), flags re-aligned by ROM_LATENCY.
// cfg_ready drops while a running update waits for the next accumulator carry to commit.
module dds_phase_gen #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int ROM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dds_phase_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t                 state, state_nxt;
  logic [PHASE_WIDTH-1:0] acc, acc_nxt;
  logic [PHASE_WIDTH-1:0] act_freq, act_freq_nxt, shd_freq, shd_freq_nxt;
  logic [ADDR_WIDTH-1:0]  act_phase, act_phase_nxt, shd_phase, shd_phase_nxt;
  logic [ADDR_WIDTH-1:0]  addr, addr_nxt;
  logic                   addr_vld, addr_vld_nxt;
  logic                   wrap_q, wrap_nxt;
  logic [PHASE_WIDTH:0]   sum;
  logic                   xfer;
  logic [ROM_LATENCY-1:0] dv_sr, ss_sr;

  assign sum           = {1'b0, acc} + {1'b0, act_freq};
  assign bus.cfg_ready = (state != PEND);
  assign xfer          = bus.cfg_valid && bus.cfg_ready;

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    act_freq_nxt  = act_freq;
    act_phase_nxt = act_phase;
    shd_freq_nxt  = shd_freq;
    shd_phase_nxt = shd_phase;
    addr_nxt      = addr;
    addr_vld_nxt  = addr_vld;
    wrap_nxt      = wrap_q;
    case (state)
      IDLE: begin
        acc_nxt      = '0;
        addr_nxt     = '0;
        addr_vld_nxt = 1'b0;
        wrap_nxt     = 1'b0;
        if (xfer) begin
          act_freq_nxt  = bus.cfg_freq;
          act_phase_nxt = bus.cfg_phase;
        end
        // First address is the phase offset itself, including one loaded on this edge.
        if (bus.en) begin
          state_nxt    = RUN;
          addr_nxt     = act_phase_nxt;
          addr_vld_nxt = 1'b1;
        end
      end
      default: begin
        if (!bus.en) begin
          state_nxt    = IDLE;
          acc_nxt      = '0;
          addr_nxt     = '0;
          addr_vld_nxt = 1'b0;
          wrap_nxt     = 1'b0;
          if (state == PEND) begin
            act_freq_nxt  = shd_freq;
            act_phase_nxt = shd_phase;
          end else if (xfer) begin
            act_freq_nxt  = bus.cfg_freq;
            act_phase_nxt = bus.cfg_phase;
          end
        end else begin
          acc_nxt      = sum[PHASE_WIDTH-1:0];
          addr_nxt     = sum[PHASE_WIDTH-1 -: ADDR_WIDTH] + act_phase;
          addr_vld_nxt = 1'b1;
          wrap_nxt     = sum[PHASE_WIDTH];
          // Pending update lands on a carry so the current cycle of the waveform completes intact.
          if (state == PEND) begin
            if (sum[PHASE_WIDTH]) begin
              act_freq_nxt  = shd_freq;
              act_phase_nxt = shd_phase;
              state_nxt     = RUN;
            end
          end else if (xfer) begin
            shd_freq_nxt  = bus.cfg_freq;
            shd_phase_nxt = bus.cfg_phase;
            state_nxt     = PEND;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      act_freq  <= '0;
      act_phase <= '0;
      shd_freq  <= '0;
      shd_phase <= '0;
      addr      <= '0;
      addr_vld  <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      act_freq  <= act_freq_nxt;
      act_phase <= act_phase_nxt;
      shd_freq  <= shd_freq_nxt;
      shd_phase <= shd_phase_nxt;
      addr      <= addr_nxt;
      addr_vld  <= addr_vld_nxt;
      wrap_q    <= wrap_nxt;
    end
  end

  // Flag delay line tracks the ROM read pipeline; en does not flush it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dv_sr <= '0;
      ss_sr <= '0;
    end else begin
      dv_sr[0] <= addr_vld;
      ss_sr[0] <= wrap_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        dv_sr[i] <= dv_sr[i-1];
        ss_sr[i] <= ss_sr[i-1];
      end
    end
  end

  assign bus.rom_addr    = addr;
  assign bus.addr_valid  = addr_vld;
  assign bus.wrap        = wrap_q;
  assign bus.data_valid  = dv_sr[ROM_LATENCY-1];
  assign bus.sample_sync = ss_sr[ROM_LATENCY-1];
endmodule
